// File: rtl/calculation_div_pkg.sv
// Shared definitions for the k-means divider: default datapath widths and FSM encoding.
package calculation_div_pkg;

  // Widths shared with the k-means multiplier and accumulator.
  localparam int unsigned KM_DATA_W = 16;
  localparam int unsigned KM_ACC_W  = 32;

  // Divider FSM encoding.
  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivRun  = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  // Width of a down-counter that must hold the value w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/calculation_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module calculation_div_step #(
  parameter int unsigned DIVISOR_W = 16
) (
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 dividend_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] p;
  logic [DIVISOR_W:0] diff;

  // Partial remainder is one bit wider than the divisor so the trial subtract cannot overflow.
  // Because r_in < divisor always holds, p < 2*divisor, so the top bit of the difference is a
  // clean borrow flag (set exactly when p < divisor).
  always_comb begin
    p     = {r_in, dividend_msb};
    diff  = p - {1'b0, divisor};
    q_bit = ~diff[DIVISOR_W];
    r_out = q_bit ? diff[DIVISOR_W-1:0] : p[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/calculation_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Quotient, remainder and the divide-by-zero flag hold until the next accepted start.
module calculation_div
  import calculation_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = KM_ACC_W,
  parameter int unsigned DIVISOR_W  = KM_DATA_W
) (
  input  logic                  div_clk,
  input  logic                  div_rst,
  input  logic                  div_start,
  input  logic [DIVIDEND_W-1:0] div_dividend,
  input  logic [DIVISOR_W-1:0]  div_divisor,
  output logic [DIVIDEND_W-1:0] div_quot,
  output logic [DIVISOR_W-1:0]  div_rem,
  output logic                  div_busy,
  output logic                  div_done,
  output logic                  div_zero
);

  localparam int unsigned      CntW    = cnt_width(DIVIDEND_W);
  localparam logic [CntW-1:0]  CntLast = CntW'(DIVIDEND_W - 1);

  div_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;   // captured divisor
  logic [DIVISOR_W-1:0]  r_q, r_d;       // partial remainder
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  zero_q, zero_d;

  logic [DIVISOR_W-1:0]  step_r;
  logic                  step_q;

  calculation_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r_in         (r_q),
    .dividend_msb (dvd_q[DIVIDEND_W-1]),
    .divisor      (dvs_q),
    .r_out        (step_r),
    .q_bit        (step_q)
  );

  // Next-state: accept starts in IDLE/DONE, iterate one step per cycle in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    zero_d  = zero_q;

    unique case (state_q)
      DivIdle, DivDone: begin
        state_d = DivIdle;
        if (div_start) begin
          if (div_divisor != '0) begin
            state_d = DivRun;
            dvd_d   = div_dividend;
            dvs_d   = div_divisor;
            r_d     = '0;
            cnt_d   = CntLast;
            zero_d  = 1'b0;
          end else begin
            // Divide by zero: saturated quotient, low dividend bits as remainder, no iteration.
            state_d = DivDone;
            quot_d  = '1;
            rem_d   = div_dividend[DIVISOR_W-1:0];
            zero_d  = 1'b1;
          end
        end
      end
      DivRun: begin
        r_d   = step_r;
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = DivDone;
          quot_d  = {dvd_q[DIVIDEND_W-2:0], step_q};
          rem_d   = step_r;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge div_clk or negedge div_rst) begin
    if (!div_rst) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    div_quot = quot_q;
    div_rem  = rem_q;
    div_zero = zero_q;
    div_busy = (state_q == DivRun);
    div_done = (state_q == DivDone);
  end

endmodule

// File: tb/tb_calculation_div.sv
// Scoreboard bench for calculation_div: driver pushes expected results on each accepted start,
// monitor pops and compares on every done pulse (value, flag, done cycle, busy length).
module tb_calculation_div;

  localparam int unsigned DW = 32;
  localparam int unsigned VW = 16;

  logic          div_clk = 1'b0;
  logic          div_rst = 1'b0;
  logic          div_start = 1'b0;
  logic [DW-1:0] div_dividend = '0;
  logic [VW-1:0] div_divisor = '0;
  logic [DW-1:0] div_quot;
  logic [VW-1:0] div_rem;
  logic          div_busy;
  logic          div_done;
  logic          div_zero;

  calculation_div #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (VW)
  ) dut (
    .div_clk      (div_clk),
    .div_rst      (div_rst),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_zero     (div_zero)
  );

  always #5 div_clk = ~div_clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int unsigned   done_cyc;
    int unsigned   busy;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;   // number of rising edges seen so far
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge div_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called #1 after the accepting edge N. Done is visible in the period following edge
  // N+DW (cycle N+DW+1), or right after edge N for a zero divisor.
  task automatic push_exp(input logic [DW-1:0] q, input logic [VW-1:0] r, input logic z);
    exp_t e;
    e.q        = q;
    e.r        = r;
    e.z        = z;
    e.done_cyc = z ? cyc : cyc + DW;
    e.busy     = z ? 0 : DW;
    sb.push_back(e);
  endtask

  // Drive a request from IDLE/DONE; returns #1 after the accepting edge.
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       input logic [DW-1:0] q, input logic [VW-1:0] r, input logic z);
    div_dividend = a;
    div_divisor  = b;
    div_start    = 1'b1;
    @(posedge div_clk);
    #1;
    push_exp(q, r, z);
    div_start = 1'b0;
  endtask

  // Wait (bounded) for a done pulse, then return #1 after the edge that ends the DONE cycle.
  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < int'(DW) + 8; i++) begin
      @(negedge div_clk);
      if (div_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: no done within %0d cycles", tag, DW + 8);
    end
    @(posedge div_clk);
    #1;
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  initial begin : monitor
    int unsigned busy_cnt;
    exp_t        e;
    busy_cnt = 0;
    forever begin
      @(negedge div_clk);
      if (!div_rst) begin
        busy_cnt = 0;
      end else begin
        if (div_busy) busy_cnt++;
        if (div_done) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: done at cycle %0d, expected none", cyc);
          end else begin
            e = sb.pop_front();
            chk("quot", 64'(div_quot), 64'(e.q));
            chk("rem", 64'(div_rem), 64'(e.r));
            chk("zero", 64'(div_zero), 64'(e.z));
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d bad", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    int unsigned   n0;

    // Reset state
    #1;
    chk("rst_quot", 64'(div_quot), 64'd0);
    chk("rst_rem", 64'(div_rem), 64'd0);
    chk("rst_busy", 64'(div_busy), 64'd0);
    chk("rst_done", 64'(div_done), 64'd0);
    chk("rst_zero", 64'(div_zero), 64'd0);
    repeat (2) @(posedge div_clk);
    #1 div_rst = 1'b1;
    @(posedge div_clk);
    #1;

    // Basic operation with latency and busy length checked by the monitor
    issue(32'd7140, 16'd14, 32'd510, 16'd0, 1'b0);
    wait_done("basic");

    // Back-to-back, start held high through DONE
    div_dividend = 32'd69732;
    div_divisor  = 16'd156;
    div_start    = 1'b1;
    @(posedge div_clk);
    #1;
    push_exp(32'd447, 16'd0, 1'b0);
    div_dividend = 32'd7800;
    div_divisor  = 16'd65;
    wait_done("b2b1");
    push_exp(32'd120, 16'd0, 1'b0);
    div_dividend = 32'd100000;
    div_divisor  = 16'd7;
    wait_done("b2b2");
    push_exp(32'd14285, 16'd5, 1'b0);
    div_start = 1'b0;
    wait_done("b2b3");

    // Divide by zero, then a normal op clears the flag
    issue(32'd1234, 16'd0, 32'hFFFF_FFFF, 16'd1234, 1'b1);
    wait_done("div0");
    issue(32'd10, 16'd3, 32'd3, 16'd1, 1'b0);
    wait_done("after_div0");

    // Start pulsed while busy plus operand changes must not disturb the running op
    issue(32'd7140, 16'd14, 32'd510, 16'd0, 1'b0);
    repeat (9) @(posedge div_clk);
    #1;
    div_start    = 1'b1;
    div_dividend = 32'd9;
    div_divisor  = 16'd3;
    @(posedge div_clk);
    #1;
    div_start    = 1'b0;
    div_dividend = 32'hDEAD_BEEF;
    div_divisor  = 16'h0003;
    wait_done("busy_start");
    repeat (40) @(posedge div_clk);
    #1;

    // Asynchronous reset mid-run: outputs clear without a clock edge, no done follows
    issue(32'd7140, 16'd14, 32'd510, 16'd0, 1'b0);
    n0 = cyc;
    while (cyc < n0 + 14) @(posedge div_clk);
    #3;
    div_rst = 1'b0;
    sb.delete();
    #1;
    chk("abort_quot", 64'(div_quot), 64'd0);
    chk("abort_rem", 64'(div_rem), 64'd0);
    chk("abort_busy", 64'(div_busy), 64'd0);
    chk("abort_done", 64'(div_done), 64'd0);
    chk("abort_zero", 64'(div_zero), 64'd0);
    repeat (2) @(posedge div_clk);
    #1 div_rst = 1'b1;
    @(posedge div_clk);
    #1;
    issue(32'd0, 16'd5, 32'd0, 16'd0, 1'b0);
    wait_done("zero_dividend");
    issue(32'd3, 16'd5, 32'd0, 16'd3, 1'b0);
    wait_done("small_dividend");

    // Boundary operands
    issue(32'h89AB_CDEF, 16'd1, 32'h89AB_CDEF, 16'd0, 1'b0);
    wait_done("div_by_one");
    issue(32'd100, 16'd1000, 32'd0, 16'd100, 1'b0);
    wait_done("lt_divisor");
    issue(32'hFFFF_FFFF, 16'hFFFF, 32'd65537, 16'd0, 1'b0);
    wait_done("max_ops");

    // Random operand pairs with a non-zero divisor
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = 16'($urandom_range(1, 65535));
      if ((i % 4) == 0) a = a >> $urandom_range(0, 31);
      if ((i % 7) == 0) b = b >> $urandom_range(0, 15);
      if (b == '0) b = 16'd1;
      issue(a, b, a / DW'(b), VW'(a % DW'(b)), 1'b0);
      wait_done("random");
    end

    repeat (40) @(posedge div_clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
